// File: rtl/valid_burst_gen_pkg.sv
// Shared types and parameter defaults for the valid->a burst stimulus generator.
package valid_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam int MIN_LEN_DEF = 3;
    localparam int MAX_LEN_DEF = 6;
    localparam int LEN_W_DEF   = 3;
    localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/valid_burst_gen_if.sv
// Request/response bundle between a burst requester (master) and the generator (slave).
interface valid_burst_gen_if
    import valid_burst_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic [LEN_W-1:0] len_in;
    logic             abort;
    logic             clr_err;
    logic             valid;
    logic             a;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             overflow;
    logic [CNT_W-1:0] burst_cnt;

    modport master (
        output start, len_in, abort, clr_err,
        input  valid, a, busy, done, aborted, overflow, burst_cnt
    );

    modport slave (
        input  start, len_in, abort, clr_err,
        output valid, a, busy, done, aborted, overflow, burst_cnt
    );
endinterface

// File: rtl/valid_burst_gen_burst_req_slot.sv
// One-deep holder for the next burst length; clamps requests into [MIN_LEN, MAX_LEN].
module burst_req_slot
    import valid_burst_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [LEN_W-1:0] len,
    output logic             full,
    output logic [LEN_W-1:0] len_q,
    output logic             drop
);

    function automatic logic [LEN_W-1:0] clamp(input logic [LEN_W-1:0] x);
        if (x < LEN_W'(MIN_LEN))
            return LEN_W'(MIN_LEN);
        else if (x > LEN_W'(MAX_LEN))
            return LEN_W'(MAX_LEN);
        else
            return x;
    endfunction

    logic             full_reg, full_next;
    logic [LEN_W-1:0] len_reg, len_next;

    // A pop in the same cycle frees the slot, so a simultaneous push is kept, not dropped.
    always_comb begin
        full_next = full_reg;
        len_next  = len_reg;
        if (push && (pop || !full_reg)) begin
            full_next = 1'b1;
            len_next  = clamp(len);
        end else if (pop) begin
            full_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_reg <= 1'b0;
            len_reg  <= '0;
        end else begin
            full_reg <= full_next;
            len_reg  <= len_next;
        end
    end

    assign full  = full_reg;
    assign len_q = len_reg;
    assign drop  = push && full_reg && !pop;

endmodule

// File: rtl/valid_burst_gen.sv
// Burst generator: 1-cycle valid pulse followed by a clamped run of a, with a one-deep
// pending request slot, abort, sticky overflow and a completed-burst counter.
module valid_burst_gen
    import valid_burst_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    valid_burst_gen_if.slave   bus
);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] count_reg, count_next;
    logic             head_reg, head_next;
    logic             valid_reg, valid_next;
    logic             a_reg, a_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             aborted_reg, aborted_next;
    logic             overflow_reg, overflow_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;

    logic             slot_push, slot_pop, slot_full, slot_drop;
    logic [LEN_W-1:0] slot_len;

    // Abort is modelled as a pop with no push, which empties the slot.
    assign slot_push = bus.start && !bus.abort;

    burst_req_slot #(
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_slot (
        .clk   (clk),
        .rst   (rst),
        .push  (slot_push),
        .pop   (slot_pop),
        .len   (bus.len_in),
        .full  (slot_full),
        .len_q (slot_len),
        .drop  (slot_drop)
    );

    // head_reg marks a VALID entered from IDLE: its length still sits in the slot.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        head_next    = head_reg;
        slot_pop     = 1'b0;
        aborted_next = 1'b0;
        if (bus.abort) begin
            state_next   = IDLE;
            head_next    = 1'b0;
            slot_pop     = 1'b1;
            aborted_next = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_next = VALID;
                        head_next  = 1'b1;
                    end
                end
                VALID: begin
                    state_next = BURST;
                    head_next  = 1'b0;
                    if (head_reg) begin
                        slot_pop   = 1'b1;
                        count_next = slot_len;
                    end
                end
                BURST: begin
                    if (count_reg == LEN_W'(1)) begin
                        if (slot_full) begin
                            slot_pop   = 1'b1;
                            count_next = slot_len;
                            state_next = VALID;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        count_next = count_reg - LEN_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are registered copies of what the next state implies.
    always_comb begin
        valid_next     = (state_next == VALID);
        a_next         = (state_next == BURST);
        busy_next      = (state_next != IDLE);
        done_next      = (state_next == BURST) && (count_next == LEN_W'(1));
        burst_cnt_next = burst_cnt_reg + CNT_W'(done_next);
        overflow_next  = slot_drop || (overflow_reg && !bus.clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            head_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            a_reg         <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            aborted_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            head_reg      <= head_next;
            valid_reg     <= valid_next;
            a_reg         <= a_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            aborted_reg   <= aborted_next;
            overflow_reg  <= overflow_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    assign bus.valid     = valid_reg;
    assign bus.a         = a_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.aborted   = aborted_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.burst_cnt = burst_cnt_reg;

endmodule

// File: tb/tb_valid_burst_gen.sv
// Directed bench for valid_burst_gen with a burst-length scoreboard and a valid->a monitor.
module tb_valid_burst_gen;
    import valid_burst_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    valid_burst_gen_if bus ();

    valid_burst_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int exp_q[$];
    int exp_cnt  = 0;
    int run      = 0;
    bit mon_en   = 1'b1;
    logic v_prev = 1'b0;
    logic a_prev = 1'b0;
    logic d_prev = 1'b0;

    function automatic int clampf(input int x);
        if (x < MIN_LEN_DEF) return MIN_LEN_DEF;
        if (x > MAX_LEN_DEF) return MAX_LEN_DEF;
        return x;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Valid->a contract monitor plus scoreboard pop at the end of each a run.
    task automatic monitor();
        int exp_len;
        if (!rst || !mon_en) begin
            run = 0;
        end else begin
            if (bus.a && !a_prev) chk("p1_valid_before_a", int'(v_prev), 1);
            if (v_prev)           chk("p1_a_after_valid", int'(bus.a), 1);
            if (bus.a) run++;
            if (!bus.a && a_prev) begin
                chk("p1_len_in_range", int'(run >= MIN_LEN_DEF && run <= MAX_LEN_DEF), 1);
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_burst", run, 0);
                end else begin
                    exp_len = exp_q.pop_front();
                    chk("sb_burst_len", run, exp_len);
                    chk("sb_done_on_last_a", int'(d_prev), 1);
                    $display("burst complete: len=%0d expected=%0d", run, exp_len);
                end
                run = 0;
            end
        end
        v_prev = bus.valid;
        a_prev = bus.a;
        d_prev = bus.done;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic req(input int len);
        bus.start  = 1'b1;
        bus.len_in = 3'(len);
        $display("start request: len_in=%0d", len);
    endtask

    task automatic run_until_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!bus.busy) break;
            tick();
        end
        chk("idle_reached", int'(bus.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start   = 1'b0;
        bus.len_in  = '0;
        bus.abort   = 1'b0;
        bus.clr_err = 1'b0;

        // Reset state
        @(negedge clk);
        monitor();
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_a", int'(bus.a), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_aborted", int'(bus.aborted), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_burst_cnt", int'(bus.burst_cnt), 0);
        rst = 1'b1;
        tick();
        tick();

        // 1: single len-4 burst, cycle-exact
        req(4); exp_q.push_back(clampf(4));
        tick();
        bus.start = 1'b0;
        chk("t1_valid", int'(bus.valid), 1);
        chk("t1_a_during_valid", int'(bus.a), 0);
        chk("t1_busy", int'(bus.busy), 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t1_a", int'(bus.a), 1);
            chk("t1_done", int'(bus.done), int'(k == 4));
            if (k == 4) chk("t1_burst_cnt", int'(bus.burst_cnt), 1);
        end
        exp_cnt = 1;
        tick();
        chk("t1_a_end", int'(bus.a), 0);
        chk("t1_busy_end", int'(bus.busy), 0);

        // 2: clamp low and high
        req(1); exp_q.push_back(clampf(1));
        tick(); bus.start = 1'b0;
        run_until_idle(20);
        req(7); exp_q.push_back(clampf(7));
        tick(); bus.start = 1'b0;
        run_until_idle(20);
        exp_cnt += 2;
        chk("t2_burst_cnt", int'(bus.burst_cnt), exp_cnt);

        // 3: pending request served back-to-back
        req(5); exp_q.push_back(clampf(5));
        tick(); bus.start = 1'b0;
        tick();
        req(3); exp_q.push_back(clampf(3));
        tick(); bus.start = 1'b0;
        tick(); tick(); tick();
        chk("t3_5th_a", int'(bus.a), 1);
        tick();
        chk("t3_second_valid", int'(bus.valid), 1);
        chk("t3_second_valid_a", int'(bus.a), 0);
        run_until_idle(30);
        exp_cnt += 2;
        chk("t3_burst_cnt", int'(bus.burst_cnt), exp_cnt);

        // 4: overflow, clr_err vs new drop, start on the draining cycle
        req(5); exp_q.push_back(clampf(5));
        tick(); bus.start = 1'b0;
        tick();
        req(3); exp_q.push_back(clampf(3));
        tick();
        chk("t4_no_overflow_yet", int'(bus.overflow), 0);
        req(4);
        tick();
        chk("t4_overflow_set", int'(bus.overflow), 1);
        req(4); bus.clr_err = 1'b1;
        tick();
        chk("t4_overflow_clr_vs_drop", int'(bus.overflow), 1);
        bus.start = 1'b0;
        tick();
        chk("t4_overflow_cleared", int'(bus.overflow), 0);
        chk("t4_last_a_done", int'(bus.done), 1);
        bus.clr_err = 1'b0;
        req(6); exp_q.push_back(clampf(6));
        tick(); bus.start = 1'b0;
        chk("t4_drain_valid", int'(bus.valid), 1);
        chk("t4_drain_not_dropped", int'(bus.overflow), 0);
        run_until_idle(40);
        exp_cnt += 3;
        chk("t4_burst_cnt", int'(bus.burst_cnt), exp_cnt);

        // 5: abort on the 2nd a cycle of a len-6 burst; start alongside abort is ignored
        mon_en = 1'b0;
        req(6);
        tick(); bus.start = 1'b0;
        tick(); tick();
        chk("t5_a2", int'(bus.a), 1);
        bus.abort = 1'b1; bus.start = 1'b1;
        tick();
        bus.abort = 1'b0; bus.start = 1'b0;
        chk("t5_a_dropped", int'(bus.a), 0);
        chk("t5_valid", int'(bus.valid), 0);
        chk("t5_aborted", int'(bus.aborted), 1);
        chk("t5_done", int'(bus.done), 0);
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_burst_cnt", int'(bus.burst_cnt), exp_cnt);
        tick();
        chk("t5_aborted_pulse", int'(bus.aborted), 0);
        chk("t5_start_ignored", int'(bus.valid), 0);
        chk("t5_still_idle", int'(bus.busy), 0);
        $display("abort taken: burst_cnt=%0d", bus.burst_cnt);
        mon_en = 1'b1;

        // 6: asynchronous reset mid-burst
        mon_en = 1'b0;
        req(6);
        tick(); bus.start = 1'b0;
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        chk("t6_valid", int'(bus.valid), 0);
        chk("t6_a", int'(bus.a), 0);
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_burst_cnt", int'(bus.burst_cnt), 0);
        $display("reset mid-burst: a=%0d busy=%0d", bus.a, bus.busy);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        chk("t6_no_restart", int'(bus.busy), 0);
        mon_en = 1'b1;
        req(3); exp_q.push_back(clampf(3));
        tick(); bus.start = 1'b0;
        run_until_idle(20);
        exp_cnt += 1;
        chk("t6_burst_cnt_after", int'(bus.burst_cnt), exp_cnt);
        chk("sb_all_consumed", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
